// File: rtl/gmii_tx_framer.sv
// Transmit framing stage ahead of the 1000BASE-T PCS encoder: preamble/SFD insertion,
// inter-frame gap enforcement and error termination on underrun or link loss.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [7:0]       io_in_data,
    input  logic             io_in_last,
    input  logic             io_link_ok,
    output logic             io_tx_enable,
    output logic [7:0]       io_tx_data,
    output logic             io_tx_error,
    output logic [31:0]      io_n,
    output logic [31:0]      io_n0,
    output logic [CNT_W-1:0] io_frames_sent,
    output logic [CNT_W-1:0] io_frames_aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_DROP,
        S_IFG
    } state_t;

    localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IFG_LAST = 8'(IFG_LEN - 1);
    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    state_t           state, state_nxt;
    logic [3:0]       pre_cnt, pre_cnt_nxt;
    logic [7:0]       ifg_cnt, ifg_cnt_nxt;
    logic             sent_pend, sent_pend_nxt;
    logic             tx_enable_nxt;
    logic             tx_error_nxt;
    logic [7:0]       tx_data_nxt;
    logic [31:0]      n0_nxt;
    logic [CNT_W-1:0] sent_nxt;
    logic [CNT_W-1:0] aborted_nxt;
    logic             start;
    logic             abort;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign io_in_ready = (state == S_DATA) || (state == S_DROP);
    assign start       = (state == S_IDLE) && io_in_valid && io_link_ok;

    // Link loss outranks a valid byte in DATA, so that byte is left for DROP to sink.
    always_comb begin
        abort = 1'b0;
        case (state)
            S_PRE, S_SFD: abort = !io_link_ok;
            S_DATA:       abort = !io_link_ok || !io_in_valid;
            default:      abort = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= S_IDLE;
            pre_cnt           <= '0;
            ifg_cnt           <= '0;
            sent_pend         <= 1'b0;
            io_tx_enable      <= 1'b0;
            io_tx_data        <= 8'h00;
            io_tx_error       <= 1'b0;
            io_n              <= '0;
            io_n0             <= '0;
            io_frames_sent    <= '0;
            io_frames_aborted <= '0;
        end else begin
            state             <= state_nxt;
            pre_cnt           <= pre_cnt_nxt;
            ifg_cnt           <= ifg_cnt_nxt;
            sent_pend         <= sent_pend_nxt;
            io_tx_enable      <= tx_enable_nxt;
            io_tx_data        <= tx_data_nxt;
            io_tx_error       <= tx_error_nxt;
            io_n              <= io_n + 32'd1;
            io_n0             <= n0_nxt;
            io_frames_sent    <= sent_nxt;
            io_frames_aborted <= aborted_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (PREAMBLE_LEN == 1) ? S_SFD : S_PRE;
            S_PRE:  if (abort) state_nxt = S_DROP;
                    else if (pre_cnt == PRE_LAST) state_nxt = S_SFD;
            S_SFD:  state_nxt = abort ? S_DROP : S_DATA;
            S_DATA: if (abort) state_nxt = S_DROP;
                    else if (io_in_last) state_nxt = S_IFG;
            S_DROP: if (io_in_valid && io_in_last) state_nxt = S_IFG;
            S_IFG:  if (ifg_cnt == IFG_LAST) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Values registered at the coming edge; pre_cnt counts preamble bytes already emitted.
    always_comb begin
        tx_enable_nxt = 1'b0;
        tx_data_nxt   = 8'h00;
        tx_error_nxt  = 1'b0;
        n0_nxt        = io_n0;
        pre_cnt_nxt   = pre_cnt;
        ifg_cnt_nxt   = ifg_cnt;
        sent_pend_nxt = 1'b0;
        sent_nxt      = sent_pend ? sat_inc(io_frames_sent) : io_frames_sent;
        aborted_nxt   = io_frames_aborted;
        if (abort) begin
            tx_enable_nxt = 1'b1;
            tx_error_nxt  = 1'b1;
            aborted_nxt   = sat_inc(io_frames_aborted);
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tx_enable_nxt = 1'b1;
                        tx_data_nxt   = PRE_BYTE;
                        n0_nxt        = io_n + 32'd1;
                        pre_cnt_nxt   = 4'd1;
                    end
                end
                S_PRE: begin
                    tx_enable_nxt = 1'b1;
                    tx_data_nxt   = PRE_BYTE;
                    pre_cnt_nxt   = pre_cnt + 4'd1;
                end
                S_SFD: begin
                    tx_enable_nxt = 1'b1;
                    tx_data_nxt   = SFD_BYTE;
                end
                S_DATA: begin
                    tx_enable_nxt = 1'b1;
                    tx_data_nxt   = io_in_data;
                    if (io_in_last) begin
                        sent_pend_nxt = 1'b1;
                        ifg_cnt_nxt   = 8'd0;
                    end
                end
                S_DROP: if (io_in_valid && io_in_last) ifg_cnt_nxt = 8'd0;
                S_IFG:  ifg_cnt_nxt = ifg_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: table of frame cases checked through a symbol scoreboard,
// plus hand-written sequences for gap timing, counter saturation and mid-frame reset.
module tb_gmii_tx_framer;

    localparam int PRE    = 7;
    localparam int IFG    = 12;
    localparam int CW     = 2;
    localparam int BUDGET = 2000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_in_valid = 1'b0;
    logic          io_in_ready;
    logic [7:0]    io_in_data = 8'h00;
    logic          io_in_last = 1'b0;
    logic          io_link_ok = 1'b1;
    logic          io_tx_enable;
    logic [7:0]    io_tx_data;
    logic          io_tx_error;
    logic [31:0]   io_n;
    logic [31:0]   io_n0;
    logic [CW-1:0] io_frames_sent;
    logic [CW-1:0] io_frames_aborted;

    gmii_tx_framer #(.PREAMBLE_LEN(PRE), .IFG_LEN(IFG), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
        .io_in_data(io_in_data), .io_in_last(io_in_last),
        .io_link_ok(io_link_ok),
        .io_tx_enable(io_tx_enable), .io_tx_data(io_tx_data), .io_tx_error(io_tx_error),
        .io_n(io_n), .io_n0(io_n0),
        .io_frames_sent(io_frames_sent), .io_frames_aborted(io_frames_aborted)
    );

    always #4 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } sym_t;

    typedef struct {
        int         len;
        int         stall_after;
        int         drop_at;
        logic [7:0] base;
        int         exp_sent;
        int         exp_aborted;
        int         exp_en;
    } vec_t;

    int      n_checks = 0;
    int      n_fail = 0;
    sym_t    exp_q[$];
    int      gap_log[$];
    logic [31:0] n0_log[$];
    bit      sb_on = 1'b1;
    int      en_cycles = 0;
    int      idle_run = 0;
    bit      prev_en = 1'b0;
    logic [31:0] model_n = 32'd0;
    vec_t    vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset) model_n <= 32'd0;
        else       model_n <= model_n + 32'd1;
    end

    always @(negedge clock) begin : monitor
        sym_t s;
        if (!reset) begin
            if (io_tx_enable) begin
                en_cycles++;
                if (!prev_en) begin
                    gap_log.push_back(idle_run);
                    n0_log.push_back(io_n0);
                    idle_run = 0;
                    check("n0_at_rise", io_n0, model_n);
                    check("n_at_rise", io_n, model_n);
                end
                if (sb_on) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_symbol", 32'(exp_q.size()), 32'd1);
                    end else begin
                        s = exp_q.pop_front();
                        check("sym_data", 32'(io_tx_data), 32'(s.data));
                        check("sym_err", 32'(io_tx_error), 32'(s.err));
                    end
                end
            end else begin
                idle_run++;
            end
            prev_en = io_tx_enable;
        end else begin
            prev_en = 1'b0;
        end
    end

    // Symbol k of a frame: preamble, SFD, then payload; aborts end in one error symbol.
    task automatic push_expected(input int len, input int stall_after, input int drop_at,
                                 input logic [7:0] base);
        int   nsym;
        sym_t s;
        if (drop_at > 0)          nsym = drop_at;
        else if (stall_after > 0) nsym = PRE + 1 + stall_after;
        else                      nsym = PRE + 1 + len;
        for (int k = 0; k < nsym; k++) begin
            if (k < PRE)       s.data = 8'h55;
            else if (k == PRE) s.data = 8'hD5;
            else               s.data = base + 8'(k - PRE - 1);
            s.err = 1'b0;
            exp_q.push_back(s);
        end
        if (drop_at > 0 || stall_after > 0) begin
            s.data = 8'h00;
            s.err  = 1'b1;
            exp_q.push_back(s);
        end
    endtask

    task automatic drive_frame(input int len, input int stall_after, input int drop_at,
                               input logic [7:0] base);
        int i = 0;
        int stall = 0;
        int cyc = 0;
        int since = 0;
        bit started = 1'b0;
        bit acc;
        push_expected(len, stall_after, drop_at, base);
        while (i < len && cyc < BUDGET) begin
            if (!started && io_tx_enable) begin
                started = 1'b1;
                since   = 1;
            end
            if (stall_after > 0 && i == stall_after && stall < 3) begin
                io_in_valid = 1'b0;
                stall++;
            end else begin
                io_in_valid = 1'b1;
                io_in_data  = base + 8'(i);
                io_in_last  = (i == len - 1);
            end
            io_link_ok = !(started && drop_at > 0 && since == drop_at);
            acc = io_in_valid && io_in_ready && io_link_ok;
            @(posedge clock); #1;
            cyc++;
            if (acc) i++;
            if (started) since++;
        end
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        io_link_ok  = 1'b1;
        check("drive_timeout", 32'(cyc < BUDGET), 32'd1);
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        io_link_ok  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic drain();
        repeat (30) @(posedge clock);
        #1;
    endtask

    initial begin
        int  cnt;
        int  cyc;
        int  e0;
        bit  ready_seen;
        bit  acc;
        int  gap1;
        logic [31:0] n0diff;

        vecs[0] = '{3,  0, 0,  8'h01, 1, 0, 11};
        vecs[1] = '{1,  0, 0,  8'hA0, 1, 0, 9};
        vecs[2] = '{10, 5, 0,  8'h10, 0, 1, 14};
        vecs[3] = '{8,  0, 3,  8'h40, 0, 1, 4};
        vecs[4] = '{4,  0, 7,  8'h60, 0, 1, 8};
        vecs[5] = '{6,  0, 10, 8'h70, 0, 1, 11};
        vecs[6] = '{5,  0, 0,  8'hFE, 1, 0, 13};
        vecs[7] = '{16, 1, 0,  8'h80, 0, 1, 10};

        apply_reset();
        check("rst_tx_enable", 32'(io_tx_enable), 32'd0);
        check("rst_tx_data", 32'(io_tx_data), 32'd0);
        check("rst_tx_error", 32'(io_tx_error), 32'd0);
        check("rst_n", io_n, 32'd0);
        check("rst_n0", io_n0, 32'd0);
        check("rst_sent", 32'(io_frames_sent), 32'd0);
        check("rst_aborted", 32'(io_frames_aborted), 32'd0);
        check("rst_ready", 32'(io_in_ready), 32'd0);

        // Valid data with the link down must never start a frame.
        io_link_ok  = 1'b0;
        io_in_valid = 1'b1;
        io_in_data  = 8'h33;
        ready_seen  = 1'b0;
        e0 = en_cycles;
        repeat (30) begin
            @(posedge clock); #1;
            if (io_in_ready) ready_seen = 1'b1;
        end
        check("idle_linkdown_no_enable", 32'(en_cycles - e0), 32'd0);
        check("idle_linkdown_no_ready", 32'(ready_seen), 32'd0);
        io_in_valid = 1'b0;
        io_link_ok  = 1'b1;

        for (int r = 0; r < 8; r++) begin
            apply_reset();
            en_cycles = 0;
            drive_frame(vecs[r].len, vecs[r].stall_after, vecs[r].drop_at, vecs[r].base);
            drain();
            check($sformatf("vec%0d_sent", r), 32'(io_frames_sent), 32'(vecs[r].exp_sent));
            check($sformatf("vec%0d_aborted", r), 32'(io_frames_aborted), 32'(vecs[r].exp_aborted));
            check($sformatf("vec%0d_en_cycles", r), 32'(en_cycles), 32'(vecs[r].exp_en));
            check($sformatf("vec%0d_sb_empty", r), 32'(exp_q.size()), 32'd0);
        end

        // Back-to-back 64-byte frames.
        apply_reset();
        gap_log.delete();
        n0_log.delete();
        drive_frame(64, 0, 0, 8'h00);
        drive_frame(64, 0, 0, 8'h40);
        drain();
        gap1   = (gap_log.size() > 1) ? gap_log[1] : -1;
        n0diff = (n0_log.size() > 1) ? (n0_log[1] - n0_log[0]) : 32'hFFFF_FFFF;
        check("b2b_rise_count", 32'(n0_log.size()), 32'd2);
        check("b2b_gap", 32'(gap1), 32'(IFG));
        check("b2b_n0_delta", n0diff, 32'd84);
        check("b2b_sent", 32'(io_frames_sent), 32'd2);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Counter saturation with a 2-bit counter.
        apply_reset();
        for (int f = 0; f < 5; f++) begin
            drive_frame(1, 0, 0, 8'(f));
            drain();
            if (f == 2) check("sat_sent_at3", 32'(io_frames_sent), 32'd3);
        end
        check("sat_sent_hold", 32'(io_frames_sent), 32'd3);
        check("sat_aborted", 32'(io_frames_aborted), 32'd0);

        // Reset asserted in the middle of a frame.
        apply_reset();
        drive_frame(4, 0, 0, 8'h20);
        drive_frame(10, 5, 0, 8'h30);
        drain();
        check("pre_midrst_sent", 32'(io_frames_sent), 32'd1);
        check("pre_midrst_aborted", 32'(io_frames_aborted), 32'd1);
        sb_on = 1'b0;
        cnt = 0;
        cyc = 0;
        io_in_valid = 1'b1;
        io_in_last  = 1'b0;
        while (cnt < 20 && cyc < BUDGET) begin
            io_in_data = 8'(cnt);
            acc = io_in_valid && io_in_ready && io_link_ok;
            @(posedge clock); #1;
            cyc++;
            if (acc) cnt++;
        end
        check("midrst_reached_byte20", 32'(cnt), 32'd20);
        check("midrst_enable_before", 32'(io_tx_enable), 32'd1);
        check("midrst_data_before", 32'(io_tx_data), 32'd19);
        reset = 1'b1;
        io_in_valid = 1'b0;
        @(posedge clock); #1;
        check("midrst_tx_enable", 32'(io_tx_enable), 32'd0);
        check("midrst_tx_error", 32'(io_tx_error), 32'd0);
        check("midrst_n", io_n, 32'd0);
        check("midrst_sent", 32'(io_frames_sent), 32'd0);
        check("midrst_aborted", 32'(io_frames_aborted), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sb_on = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("post_rst_idle", 32'(io_tx_enable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
- Transmit framing stage that sits directly upstream of the 1000BASE-T PCS encoder.
- Accepts a byte stream from the MAC-side datapath over a valid/ready/last handshake.
- Produces the encoder's GMII-style inputs (io_tx_enable, io_tx_data, io_tx_error) together with the time index io_n and frame start index io_n0.
- Inserts preamble/SFD, enforces the inter-frame gap, and converts stream underrun or link loss into a GMII error-terminated frame.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (1..15).
- IFG_LEN, 12, minimum idle cycles between the tx_enable fall and the next tx_enable rise (1..255).
- CNT_W, 16, width of the saturating frame statistics counters.

Ports:
- clock  input  1  single clock, 125 MHz GMII rate.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  upstream byte valid.
- io_in_ready  output  1  byte accepted when valid&&ready at a rising edge.
- io_in_data  input  8  upstream byte.
- io_in_last  input  1  marks final byte of frame.
- io_link_ok  input  1  local receiver status; gates frame start and aborts a frame on loss.
- io_tx_enable  output  1  to encoder.
- io_tx_data  output  8  to encoder.
- io_tx_error  output  1  to encoder.
- io_n  output  32  free-running symbol-period index to encoder.
- io_n0  output  32  value of io_n on the cycle io_tx_enable first rose for the current/last frame.
- io_frames_sent  output  CNT_W  frames completed with last, saturating.
- io_frames_aborted  output  CNT_W  frames terminated by underrun or link loss, saturating.

Behaviour:
- All outputs except io_in_ready are registered. io_in_ready is combinational from state only: high in DATA and DROP, low otherwise.
- Reset values: tx_enable=0, tx_data=0x00, tx_error=0, n=0, n0=0, both counters 0, state=IDLE. Reset mid-frame drops tx_enable on the next edge with no error cycle; the partial frame is not counted.
- io_n increments by 1 every non-reset cycle and wraps from 0xFFFFFFFF to 0.
- States: IDLE, PRE, SFD, DATA, DROP, IFG.
- IDLE:
  - Start when in_valid && link_ok at an edge. The byte is NOT consumed.
  - -> PRE. That edge registers tx_enable=1, tx_data=0x55, and n0=current n.
  - IDLE otherwise drives tx_enable=0, tx_data=0x00.
- PRE: emits 0x55 for PREAMBLE_LEN cycles in total, then SFD.
- SFD: outputs 0xD5 for one cycle, then DATA.
- DATA:
  - Each accepted byte appears on tx_data on the cycle after the accepting edge, with tx_enable=1, tx_error=0.
  - Accepted byte with in_last=1: the next edge drops tx_enable, frames_sent+1, -> IFG.
- Underrun (DATA and in_valid=0 at an edge) or link loss (DATA and link_ok=0):
  - Register tx_enable=1, tx_error=1, tx_data=0x00 for one cycle, frames_aborted+1.
  - Then tx_enable=0 and -> DROP. Link loss takes priority over a simultaneously valid byte: the byte is not consumed.
- Link loss during PRE or SFD: same one-cycle error termination, then DROP.
- DROP: tx_enable=0, discards bytes until in_last accepted, then -> IFG. If already past last, go straight to IFG.
- IFG: counts IFG_LEN cycles starting on the first tx_enable=0 cycle. New start is sampled in IDLE only, so the gap is at least IFG_LEN cycles and back-to-back frames see exactly IFG_LEN idle cycles.
- Single-byte frame (first byte has last=1): preamble, SFD, 1 data cycle, then IFG.
- Counters saturate at all-ones.

Test Plan:
- Reset 4 cycles, feed frame 0x01,0x02,0x03 (last on 0x03), link_ok=1 -> tx_data 0x55 x7, 0xD5, 0x01, 0x02, 0x03 with tx_enable=1 for 11 cycles, tx_error=0, n0 = n at first 0x55, frames_sent=1.
- Two 64-byte frames offered back-to-back -> exactly 12 cycles tx_enable=0 between frames; second n0 - first n0 = 84.
- Deassert in_valid after byte 5 of 10, then resume -> one cycle tx_enable=1, tx_error=1, tx_data=0x00; remaining 5 bytes sunk with tx_enable=0; frames_aborted=1, frames_sent unchanged.
- Drop link_ok during preamble cycle 3 -> error cycle on next output, then DROP sinks whole frame; no SFD emitted; in_valid with link_ok=0 in IDLE never starts a frame.
- Assert reset during DATA byte 20 -> tx_enable=0, tx_error=0, n=0 on next cycle; counters 0.
- Force frames_sent to 0xFFFF via 65536 single-byte frames (or CNT_W=2 build: 4 frames) -> counter holds at max.
